hilo_mdu: RTL and testbench
===========================

# hilo_mdu

Execute-stage multiply/divide unit owning the HI and LO architectural registers. It accepts mult/multu/div/divu/mthi/mtlo from the E stage and runs multi-cycle operations. It drives `E_HILObusy`, which the stall controller consumes to hold any md/mf/mt instruction in D. It also supplies HI/LO read data to the E-stage mfhi/mflo path.

## Interface
Parameters:
- `MULT_CYCLES`, 5, busy cycles after a mult/multu start (legal 1..15)
- `DIV_CYCLES`, 10, busy cycles after a div/divu start (legal 1..15)

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high
- `E_A`  in  32  forwarded rs value (dividend / multiplicand / mthi-mtlo source)
- `E_B`  in  32  forwarded rt value (divisor / multiplier)
- `E_MDOp`  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- `E_HILObusy`  out  1  start-in-progress or operation pending
- `HI`  out  32  architectural HI register
- `LO`  out  32  architectural LO register

## Operation
- Internal state: `cnt` (4 bits), `hi_tmp`/`lo_tmp` (32 each), `HI`, `LO`.
- Start = `E_MDOp` ∈ {1..4} and `cnt == 0`.
- On a start edge:
  - `cnt` ← MULT_CYCLES for ops 1–2, DIV_CYCLES for ops 3–4.
  - The result is computed combinationally from `E_A`/`E_B` and latched into `hi_tmp`/`lo_tmp`.
- mult: signed 32×32 → 64; `hi_tmp` = [63:32], `lo_tmp` = [31:0]. multu: the same, unsigned.
- div (signed):
  - `lo_tmp` = quotient, truncated toward zero.
  - `hi_tmp` = remainder, carrying the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- divu: unsigned quotient and remainder.
- Divide by zero (`E_B == 0`, div or divu): the full busy period still runs; HI/LO are left unchanged at completion.
- Each edge with `cnt > 0` and no reset: `cnt` ← `cnt − 1`. When `cnt == 1`, HI ← `hi_tmp` and LO ← `lo_tmp` on the same edge.
- mthi (5) / mtlo (6) with `cnt == 0`: HI (or LO) ← `E_A` at the edge; no busy period; the other register is unchanged.
- Any op 1–6 presented while `cnt != 0` is ignored: no state change. The stall controller prevents this; the bench checks it as robustness.
- `E_HILObusy` = (`E_MDOp` ∈ {1..6}) | (`cnt != 0`).
  - This is combinational on `E_MDOp`, so a D-stage md/mf/mt instruction stalls in the same cycle its predecessor sits in E.
  - mthi/mtlo assert busy only in their own E cycle.
- Reset: `cnt` ← 0, HI ← 0, LO ← 0, `hi_tmp`/`lo_tmp` ← 0. A pending result is discarded, including one whose `cnt == 1` edge coincides with reset.

## Timing
- Reset values: HI = 0, LO = 0, `E_HILObusy` = 0 (with `E_MDOp` = 0).
- Mult/div start in E during cycle t:
  - `E_HILObusy` is high in cycles t .. t+N, where N = MULT_CYCLES or DIV_CYCLES.
  - The new HI/LO are visible from cycle t+N+1, when busy is also low.
- mfhi/mflo in E at cycle t+N+1 reads the new value; there is no extra bypass.
- mthi/mtlo in E at cycle t: the value is visible on HI/LO from cycle t+1.
- Back-to-back: a new start is accepted in the first cycle where `cnt == 0`, i.e. cycle t+N+1.
- Arithmetic uses 64-bit products. Division uses 32-bit operands with explicit sign handling; no X for any operand value.

## Test plan
- Reset, then mult with A = 0xFFFFFFFE (−2), B = 3 at cycle t → busy high t..t+5; from t+6, HI = 0xFFFFFFFF and LO = 0xFFFFFFFA. multu with the same operands → HI = 0x00000002, LO = 0xFFFFFFFA.
- div with A = −7 (0xFFFFFFF9), B = 2 → busy t..t+10; from t+11, LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. divu with A = 7, B = 2 → LO = 3, HI = 1.
- Edge divides:
  - div 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
  - After mthi 0x1234 and mtlo 0x5678, divu by 0 → busy 11 cycles; HI = 0x1234 and LO = 0x5678 are retained.
- mthi A = 0xDEADBEEF at t → busy high only in t; HI = 0xDEADBEEF at t+1; LO unchanged.
- mult started, then at cycle t+2 present mtlo 0xAAAA and a second mult → both are ignored; the first result lands at t+6 and busy falls at t+6.
- div started, then reset asserted at t+10 (the `cnt == 1` edge) → HI = LO = 0 and busy = 0 the next cycle; no late result write.

Source files
------------

// File: rtl/hilo_mdu.sv
// hilo_mdu: execute-stage multiply/divide unit owning the HI/LO registers, with stall-facing busy flag
module hilo_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic [2:0]  E_MDOp,
  output logic        E_HILObusy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  logic [3:0]  cnt;
  logic [31:0] hi_tmp, lo_tmp;
  logic        start, is_mul, sdiv, a_neg, b_neg;
  logic [31:0] ua, ub, uq, ur, q, r, res_hi, res_lo;
  logic [63:0] prod;
  always_comb begin
    start  = E_MDOp >= 3'd1 && E_MDOp <= 3'd4 && cnt == 4'd0;
    is_mul = E_MDOp == 3'd1 || E_MDOp == 3'd2;
    sdiv   = E_MDOp == 3'd3;
    a_neg  = sdiv && E_A[31];
    b_neg  = sdiv && E_B[31];
    ua     = a_neg ? -E_A : E_A;
    ub     = b_neg ? -E_B : E_B;
    uq     = ub == 32'd0 ? 32'd0 : ua / ub;
    ur     = ub == 32'd0 ? 32'd0 : ua % ub;
    q      = (a_neg ^ b_neg) ? -uq : uq;
    r      = a_neg ? -ur : ur;
    prod   = E_MDOp == 3'd1 ? {{32{E_A[31]}}, E_A} * {{32{E_B[31]}}, E_B}
                            : {32'd0, E_A} * {32'd0, E_B};
    res_hi = is_mul ? prod[63:32] : (E_B == 32'd0 ? HI : r);
    res_lo = is_mul ? prod[31:0]  : (E_B == 32'd0 ? LO : q);
    E_HILObusy = (E_MDOp >= 3'd1 && E_MDOp <= 3'd6) || cnt != 4'd0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= 4'd0;
      hi_tmp <= 32'd0;
      lo_tmp <= 32'd0;
      HI     <= 32'd0;
      LO     <= 32'd0;
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        HI <= hi_tmp;
        LO <= lo_tmp;
      end
    end else if (start) begin
      cnt    <= is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
      hi_tmp <= res_hi;
      lo_tmp <= res_lo;
    end else if (E_MDOp == 3'd5) begin
      HI <= E_A;
    end else if (E_MDOp == 3'd6) begin
      LO <= E_A;
    end
  end
endmodule

// File: tb/tb_hilo_mdu.sv
// tb_hilo_mdu: scoreboard bench driving directed hilo_mdu vectors and checking busy/HI/LO every cycle
module tb_hilo_mdu;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] E_A, E_B;
  logic [2:0]  E_MDOp;
  logic        E_HILObusy;
  logic [31:0] HI, LO;
  typedef struct {
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    string       tag;
  } exp_t;
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cur_hi = 32'd0;
  logic [31:0] cur_lo = 32'd0;
  hilo_mdu dut (
    .clk(clk), .reset(reset), .E_A(E_A), .E_B(E_B), .E_MDOp(E_MDOp),
    .E_HILObusy(E_HILObusy), .HI(HI), .LO(LO)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (E_HILObusy !== e.busy || HI !== e.hi || LO !== e.lo) begin
        errors++;
        $display("FAIL %s: got busy=%b HI=%h LO=%h, want busy=%b HI=%h LO=%h",
                 e.tag, E_HILObusy, HI, LO, e.busy, e.hi, e.lo);
      end
    end
  end
  task automatic cyc(input logic r, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic eb, input logic [31:0] eh, input logic [31:0] el, input string tag);
    reset  = r;
    E_MDOp = op;
    E_A    = a;
    E_B    = b;
    sb.push_back('{eb, eh, el, tag});
    @(posedge clk);
    #1;
  endtask
  task automatic md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int n,
                    input logic [31:0] eh, input logic [31:0] el, input string tag);
    cyc(0, op, a, b, 1, cur_hi, cur_lo, {tag, "_start"});
    repeat (n) cyc(0, 3'd0, 32'd0, 32'd0, 1, cur_hi, cur_lo, {tag, "_busy"});
    cur_hi = eh;
    cur_lo = el;
    cyc(0, 3'd0, 32'd0, 32'd0, 0, cur_hi, cur_lo, {tag, "_done"});
  endtask
  task automatic mt(input logic [2:0] op, input logic [31:0] a, input string tag);
    cyc(0, op, a, 32'd0, 1, cur_hi, cur_lo, {tag, "_issue"});
    if (op == 3'd5) cur_hi = a;
    else cur_lo = a;
    cyc(0, 3'd0, 32'd0, 32'd0, 0, cur_hi, cur_lo, {tag, "_after"});
  endtask
  initial begin
    reset  = 1'b1;
    E_MDOp = 3'd0;
    E_A    = 32'd0;
    E_B    = 32'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    cyc(0, 3'd0, 32'd0, 32'd0, 0, 32'd0, 32'd0, "reset_state");
    md(3'd1, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, "mult");
    md(3'd2, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA, "multu");
    md(3'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
    md(3'd3, 32'd7, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD, "div_negdivisor");
    md(3'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3, "divu");
    md(3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000, "div_ovf");
    mt(3'd5, 32'h1234, "mthi");
    mt(3'd6, 32'h5678, "mtlo");
    md(3'd4, 32'd99, 32'd0, 10, 32'h1234, 32'h5678, "divu_by0");
    md(3'd3, 32'd99, 32'd0, 10, 32'h1234, 32'h5678, "div_by0");
    mt(3'd5, 32'hDEADBEEF, "mthi2");
    cyc(0, 3'd1, 32'd2, 32'd3, 1, cur_hi, cur_lo, "ign_start");
    cyc(0, 3'd0, 32'd0, 32'd0, 1, cur_hi, cur_lo, "ign_busy1");
    cyc(0, 3'd6, 32'hAAAA, 32'd0, 1, cur_hi, cur_lo, "ign_mtlo");
    cyc(0, 3'd1, 32'd7, 32'd7, 1, cur_hi, cur_lo, "ign_mult");
    cyc(0, 3'd0, 32'd0, 32'd0, 1, cur_hi, cur_lo, "ign_busy4");
    cyc(0, 3'd0, 32'd0, 32'd0, 1, cur_hi, cur_lo, "ign_busy5");
    cur_hi = 32'd0;
    cur_lo = 32'd6;
    cyc(0, 3'd0, 32'd0, 32'd0, 0, cur_hi, cur_lo, "ign_done");
    cyc(0, 3'd0, 32'd0, 32'd0, 0, cur_hi, cur_lo, "ign_hold");
    cyc(0, 3'd3, 32'd100, 32'd7, 1, cur_hi, cur_lo, "rst_start");
    repeat (9) cyc(0, 3'd0, 32'd0, 32'd0, 1, cur_hi, cur_lo, "rst_busy");
    cyc(1, 3'd0, 32'd0, 32'd0, 1, cur_hi, cur_lo, "rst_edge");
    cur_hi = 32'd0;
    cur_lo = 32'd0;
    repeat (3) cyc(0, 3'd0, 32'd0, 32'd0, 0, cur_hi, cur_lo, "rst_after");
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
